// File: rtl/mult_div_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// signed or unsigned, with a start/busy/done handshake and a fast divide-by-zero exit.
module mult_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned ACC_W = 2 * WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_ADJ  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             div_op_q, div_op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Operand magnitudes; unsigned ops never report a negative sign.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

  // Per-step datapath: multiply partial sum and restoring-divide trial subtraction.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  assign mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, opa_q};
  assign div_trial = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, opb_q};

  // Sign fix-up applied in ADJ.
  logic             res_neg;
  logic [ACC_W-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  assign res_neg  = sign_a_q ^ sign_b_q;
  assign prod_fix = res_neg ? (~acc_q + ACC_W'(1)) : acc_q;
  assign quot_fix = res_neg ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? (~rem_q + WIDTH'(1)) : rem_q;

  always_comb begin
    state_d  = state_q;
    div_op_d = div_op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          div_op_d = op[1];
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          opa_d    = a_mag;
          opb_d    = b_mag;
          dz_d     = 1'b0;
          cnt_d    = '0;
          rem_d    = '0;
          // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
          acc_d    = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          if (op[1] && (b == '0)) begin
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (div_op_q) begin
          rem_d = div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0];
          acc_d = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[ACC_W-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_ADJ;
        end
      end
      ST_ADJ: begin
        if (div_op_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[ACC_W-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CALC) || (state_d == ST_ADJ);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      div_op_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_op_q <= div_op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_iter.sv
// Directed and random checks of mult_div_iter at WIDTH=32 (scoreboarded) and WIDTH=8.
module tb_mult_div_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, div_zero8;
  logic [7:0]  hi8, lo8;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic [7:0]  lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_hi = '0, last_lo = '0;

  mult_div_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model built from wide native arithmetic.
  function automatic exp_t model(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    exp_t e;
    logic signed [63:0] sa, sb, sr;
    logic [63:0] ua, ub, ur;
    sa = {{32{a_i[31]}}, a_i};
    sb = {{32{b_i[31]}}, b_i};
    ua = {32'b0, a_i};
    ub = {32'b0, b_i};
    e.dz  = 1'b0;
    e.lat = 8'd34;
    e.hi  = last_hi;
    e.lo  = last_lo;
    case (op_i)
      2'b00: begin sr = sa * sb; e.hi = sr[63:32]; e.lo = sr[31:0]; end
      2'b01: begin ur = ua * ub; e.hi = ur[63:32]; e.lo = ur[31:0]; end
      default: begin
        if (b_i == 32'd0) begin
          e.dz  = 1'b1;
          e.lat = 8'd1;
        end else if (op_i == 2'b10) begin
          sr = sa / sb; e.lo = sr[31:0];
          sr = sa % sb; e.hi = sr[31:0];
        end else begin
          ur = ua / ub; e.lo = ur[31:0];
          ur = ua % ub; e.hi = ur[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Issue one op; optionally hold start (with junk operands) for a few busy cycles.
  task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input int hold);
    exp_t e;
    int cyc, busy_cnt;
    @(negedge clk);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    e = model(op_i, a_i, b_i);
    sb_q.push_back(e);
    last_hi = e.hi; last_lo = e.lo;
    @(posedge clk);
    #1;
    start = (hold > 0);
    op = 2'($urandom); a = $urandom; b = $urandom;
    cyc = 0; busy_cnt = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc >= hold) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) break;
      if (cyc > 100) begin
        check("timeout", 64'(cyc), 64'(e.lat));
        void'(sb_q.pop_front());
        return;
      end
    end
    e = sb_q.pop_front();
    check("latency", 64'(cyc), 64'(e.lat));
    check("busy_cycles", 64'(busy_cnt), e.dz ? 64'd0 : 64'd33);
    check("hi", 64'(hi), 64'(e.hi));
    check("lo", 64'(lo), 64'(e.lo));
    check("div_zero", 64'(div_zero), 64'(e.dz));
    @(negedge clk);
    check("done_pulse", 64'({done, busy}), 64'd0);
  endtask

  task automatic run_op8(input logic [1:0] op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                         input logic [7:0] ehi, input logic [7:0] elo);
    int cyc;
    @(negedge clk);
    start8 = 1'b1; op8 = op_i; a8 = a_i; b8 = b_i;
    @(posedge clk);
    #1 start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc <= 50) begin
      @(negedge clk);
      cyc++;
    end
    check("w8_latency", 64'(cyc), 64'd10);
    check("w8_hi", 64'(hi8), 64'(ehi));
    check("w8_lo", 64'(lo8), 64'(elo));
  endtask

  initial begin
    int dones;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({busy, done, div_zero, hi, lo}), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b11, 32'd100, 32'd7, 0);
    run_op(2'b11, 32'd12345, 32'd0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'd5, 32'hFFFF_FFFE, 0);
    run_op(2'b10, 32'd1, 32'd0, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(2'b11, 32'd3, 32'd9, 0);
    run_op(2'b00, 32'd1234, 32'hFFFF_FF00, 6);
    for (int i = 0; i < 8; i++) begin
      run_op(2'($urandom), $urandom, $urandom, 0);
    end

    // Async reset mid-multiply: outputs clear at once and the aborted op never completes.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd77; b = 32'd99;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1 check("async_reset", 64'({busy, done, div_zero, hi, lo}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    last_hi = '0; last_lo = '0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no_done_after_reset", 64'(dones), 64'd0);

    run_op(2'b11, 32'd50, 32'd0, 0);
    run_op(2'b01, 32'd6, 32'd7, 0);

    run_op8(2'b00, 8'h80, 8'h80, 8'h40, 8'h00);
    run_op8(2'b11, 8'd200, 8'd7, 8'd4, 8'd28);
    run_op8(2'b10, 8'h80, 8'hFF, 8'h00, 8'h80);
    run_op8(2'b00, 8'hFD, 8'd7, 8'hFF, 8'hEB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
